// File: rtl/wb_sdram_arbiter.sv
// Shares one pipelined Wishbone slave between N_MASTERS masters, with an in-order owner FIFO for ack routing.
// Default is round-robin grant; define WB_SDRAM_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module wb_sdram_arbiter #(
  parameter int N_MASTERS       = 2,
  parameter int ADDR_BITS       = 23,
  parameter int DATA_BYTES      = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk,
  input  logic                                   sresetn,
  input  logic [N_MASTERS*ADDR_BITS-1:0]         s_wb_addr,
  input  logic [N_MASTERS*DATA_BYTES*8-1:0]      s_wb_dat_m2s,
  input  logic [N_MASTERS-1:0]                   s_wb_we,
  input  logic [N_MASTERS-1:0]                   s_wb_stb,
  output logic [N_MASTERS-1:0]                   s_wb_stall,
  output logic [N_MASTERS-1:0]                   s_wb_ack,
  output logic [DATA_BYTES*8-1:0]                s_wb_dat_s2m,
  output logic [ADDR_BITS-1:0]                   m_wb_addr,
  output logic [DATA_BYTES*8-1:0]                m_wb_dat_m2s,
  output logic                                   m_wb_we,
  output logic                                   m_wb_stb,
  input  logic                                   m_wb_stall,
  input  logic                                   m_wb_ack,
  input  logic [DATA_BYTES*8-1:0]                m_wb_dat_s2m,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
  output logic                                   err_ack
);
  localparam int DW = DATA_BYTES * 8;
  localparam int IW = $clog2(N_MASTERS);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [N_MASTERS-1:0] ONE_N = {{(N_MASTERS-1){1'b0}}, 1'b1};

  logic [ADDR_BITS-1:0] addr_a [N_MASTERS];
  logic [DW-1:0]        dat_a  [N_MASTERS];

  logic [IW-1:0]        gnt_q;
  logic [IW-1:0]        gnt_idx;
  logic [IW-1:0]        cand;
  logic                 gnt_vld;
  logic [N_MASTERS-1:0] gnt;
  logic                 locked;
`ifndef WB_SDRAM_ARB_FIXED_PRIO_EN
  logic [IW-1:0]        last_q;
`endif

  logic [IW-1:0]        fifo_mem [MAX_OUTSTANDING];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 issue;
  logic                 pop;

  for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
    assign addr_a[i] = s_wb_addr[i*ADDR_BITS +: ADDR_BITS];
    assign dat_a[i]  = s_wb_dat_m2s[i*DW +: DW];
  end

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // A stalled request keeps its grant so the slave never sees the request change mid-stall.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (locked && s_wb_stb[gnt_q]) begin
      gnt_vld = 1'b1;
      gnt_idx = gnt_q;
    end else begin
      for (int k = 0; k < N_MASTERS; k++) begin
`ifdef WB_SDRAM_ARB_FIXED_PRIO_EN
        cand = IW'(k);
`else
        cand = IW'((int'(last_q) + 1 + k) % N_MASTERS);
`endif
        if (!gnt_vld && s_wb_stb[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign gnt        = gnt_vld ? (ONE_N << gnt_idx) : '0;
  assign fifo_full  = (count == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (count == '0);

  assign m_wb_stb     = gnt_vld & ~fifo_full & sresetn;
  assign m_wb_addr    = gnt_vld ? addr_a[gnt_idx] : '0;
  assign m_wb_dat_m2s = gnt_vld ? dat_a[gnt_idx] : '0;
  assign m_wb_we      = gnt_vld ? s_wb_we[gnt_idx] : 1'b0;
  assign s_wb_stall   = sresetn ? (~gnt | {N_MASTERS{m_wb_stall | fifo_full}}) : '1;

  assign issue        = m_wb_stb & ~m_wb_stall;
  assign pop          = m_wb_ack & ~fifo_empty & sresetn;
  assign s_wb_ack     = pop ? (ONE_N << fifo_mem[rd_ptr]) : '0;
  assign s_wb_dat_s2m = m_wb_dat_s2m;
  assign outstanding  = count;

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      locked  <= 1'b0;
      gnt_q   <= '0;
`ifndef WB_SDRAM_ARB_FIXED_PRIO_EN
      last_q  <= IW'(N_MASTERS - 1);
`endif
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_ack <= 1'b0;
    end else begin
      locked <= m_wb_stb & m_wb_stall;
      if (m_wb_stb & m_wb_stall) gnt_q <= gnt_idx;
      if (issue) begin
`ifndef WB_SDRAM_ARB_FIXED_PRIO_EN
        last_q <= gnt_idx;
`endif
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (issue && !pop)      count <= count + 1'b1;
      else if (pop && !issue) count <= count - 1'b1;
      if (m_wb_ack && fifo_empty) err_ack <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) fifo_mem[wr_ptr] <= gnt_idx;
  end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Bench for wb_sdram_arbiter: queue-based owner model checked every cycle, plus directed literal scenarios.
`timescale 1ns/1ps
module tb_wb_sdram_arbiter;
  localparam int N    = 2;
  localparam int A    = 23;
  localparam int DB   = 2;
  localparam int DW   = DB * 8;
  localparam int MAXO = 4;
  localparam int CW   = $clog2(MAXO + 1);
  localparam logic [A-1:0] ADDR0 = 23'h0000AA;
  localparam logic [A-1:0] ADDR1 = 23'h0000BB;

  logic            clk = 1'b0;
  logic            sresetn = 1'b0;
  logic [N*A-1:0]  s_wb_addr;
  logic [N*DW-1:0] s_wb_dat_m2s;
  logic [N-1:0]    s_wb_we, s_wb_stb, s_wb_stall, s_wb_ack;
  logic [DW-1:0]   s_wb_dat_s2m, m_wb_dat_m2s, m_wb_dat_s2m;
  logic [A-1:0]    m_wb_addr;
  logic            m_wb_we, m_wb_stb, m_wb_stall, m_wb_ack;
  logic [CW-1:0]   outstanding;
  logic            err_ack;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: owners of accepted requests in issue order
  int mq[$];
  int m_last;
  bit m_lock;
  int m_lock_idx;
  bit m_err;

  always #5 clk = ~clk;

  wb_sdram_arbiter #(
    .N_MASTERS(N), .ADDR_BITS(A), .DATA_BYTES(DB), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .sresetn(sresetn),
    .s_wb_addr(s_wb_addr), .s_wb_dat_m2s(s_wb_dat_m2s), .s_wb_we(s_wb_we), .s_wb_stb(s_wb_stb),
    .s_wb_stall(s_wb_stall), .s_wb_ack(s_wb_ack), .s_wb_dat_s2m(s_wb_dat_s2m),
    .m_wb_addr(m_wb_addr), .m_wb_dat_m2s(m_wb_dat_m2s), .m_wb_we(m_wb_we), .m_wb_stb(m_wb_stb),
    .m_wb_stall(m_wb_stall), .m_wb_ack(m_wb_ack), .m_wb_dat_s2m(m_wb_dat_s2m),
    .outstanding(outstanding), .err_ack(err_ack)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int g;
    int c;
    int start;
    bit full;
    bit e_stb;
    logic [A-1:0]  e_addr;
    logic [DW-1:0] e_dat;
    logic          e_we;
    logic [N-1:0]  e_stall;
    logic [N-1:0]  e_ack;
    if (!sresetn) begin
      mq.delete();
      m_last = N - 1;
      m_lock = 1'b0;
      m_lock_idx = 0;
      m_err = 1'b0;
      chk("rst_m_stb", m_wb_stb, 0);
      chk("rst_stall", s_wb_stall, {N{1'b1}});
      chk("rst_ack", s_wb_ack, 0);
      chk("rst_outstanding", outstanding, 0);
      chk("rst_err_ack", err_ack, 0);
    end else begin
      g = -1;
`ifdef WB_SDRAM_ARB_FIXED_PRIO_EN
      start = 0;
`else
      start = (m_last + 1) % N;
`endif
      if (m_lock && s_wb_stb[m_lock_idx]) g = m_lock_idx;
      else begin
        for (int k = 0; k < N; k++) begin
          c = (start + k) % N;
          if (g < 0 && s_wb_stb[c]) g = c;
        end
      end
      full   = (mq.size() == MAXO);
      e_stb  = (g >= 0) && !full;
      e_addr = (g >= 0) ? s_wb_addr[g*A +: A] : '0;
      e_dat  = (g >= 0) ? s_wb_dat_m2s[g*DW +: DW] : '0;
      e_we   = (g >= 0) ? s_wb_we[g] : 1'b0;
      for (int i = 0; i < N; i++) e_stall[i] = (g == i) ? (m_wb_stall | full) : 1'b1;
      e_ack = '0;
      if (m_wb_ack && mq.size() > 0) e_ack[mq[0]] = 1'b1;

      chk("m_stb", m_wb_stb, e_stb);
      chk("m_addr", m_wb_addr, e_addr);
      chk("m_dat", m_wb_dat_m2s, e_dat);
      chk("m_we", m_wb_we, e_we);
      chk("s_stall", s_wb_stall, e_stall);
      chk("s_ack", s_wb_ack, e_ack);
      chk("s_dat", s_wb_dat_s2m, m_wb_dat_s2m);
      chk("outstanding", outstanding, mq.size());
      chk("err_ack", err_ack, m_err);

      if (m_wb_ack) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else m_err = 1'b1;
      end
      if (e_stb && !m_wb_stall) begin
        mq.push_back(g);
        m_last = g;
      end
      m_lock = e_stb && m_wb_stall;
      if (m_lock) m_lock_idx = g;
    end
  end

  task automatic set_m(input int i, input logic [A-1:0] a, input logic [DW-1:0] d, input logic we);
    s_wb_addr[i*A +: A]      = a;
    s_wb_dat_m2s[i*DW +: DW] = d;
    s_wb_we[i]               = we;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 sresetn = 1'b0;
    s_wb_stb = '0; m_wb_ack = 1'b0; m_wb_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1 sresetn = 1'b1;
  endtask

  initial begin
    int rem [N];
    int ord [8];
    s_wb_addr = '0; s_wb_dat_m2s = '0; s_wb_we = '0; s_wb_stb = '0;
    m_wb_stall = 1'b0; m_wb_ack = 1'b0; m_wb_dat_s2m = '0;
    repeat (3) @(posedge clk);
    #1 sresetn = 1'b1;

    // single master write then read
    set_m(0, '0, 16'h5555, 1'b1);
    s_wb_stb = 2'b01;
    #2;
    chk("t1_stb", m_wb_stb, 1);
    chk("t1_addr", m_wb_addr, 0);
    chk("t1_we", m_wb_we, 1);
    chk("t1_wdat", m_wb_dat_m2s, 16'h5555);
    chk("t1_stall", s_wb_stall, 2'b10);
    tick();
    set_m(0, '0, 16'h0000, 1'b0);
    m_wb_ack = 1'b1;
    #2;
    chk("t1_wr_ack", s_wb_ack, 2'b01);
    chk("t1_rd_we", m_wb_we, 0);
    chk("t1_rd_stb", m_wb_stb, 1);
    tick();
    s_wb_stb = '0;
    m_wb_dat_s2m = 16'h5555;
    #2;
    chk("t1_rd_ack", s_wb_ack, 2'b01);
    chk("t1_rd_dat", s_wb_dat_s2m, 16'h5555);
    chk("t1_outstanding", outstanding, 1);
    tick();
    m_wb_ack = 1'b0;
    #2 chk("t1_drained", outstanding, 0);

    // contention: both masters want four requests each
    do_reset();
`ifdef WB_SDRAM_ARB_FIXED_PRIO_EN
    ord = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
    ord = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
    set_m(0, ADDR0, 16'h1111, 1'b1);
    set_m(1, ADDR1, 16'h2222, 1'b0);
    rem[0] = 4; rem[1] = 4;
    for (int k = 0; k <= 8; k++) begin
      for (int i = 0; i < N; i++) s_wb_stb[i] = (rem[i] > 0);
      m_wb_ack = (k > 0);
      #2;
      if (k < 8) chk("cont_order", m_wb_addr, (ord[k] == 0) ? ADDR0 : ADDR1);
      if (k > 0) chk("cont_ack", s_wb_ack, 1 << ord[k-1]);
      for (int i = 0; i < N; i++) if (s_wb_stb[i] && !s_wb_stall[i]) rem[i]--;
      tick();
    end
    m_wb_ack = 1'b0;
    s_wb_stb = '0;

    // stall lock: master 1 holds the slave through 5 stalled cycles
    for (int k = 0; k <= 8; k++) begin
      s_wb_stb   = (k == 0) ? 2'b10 : (k <= 5) ? 2'b11 : (k == 6) ? 2'b01 : 2'b00;
      m_wb_stall = (k <= 4);
      m_wb_ack   = (k >= 7);
      #2;
      if (k <= 5) chk("lock_addr", m_wb_addr, ADDR1);
      if (k <= 4) chk("lock_stall", s_wb_stall, 2'b11);
      if (k == 5) chk("lock_release_stall", s_wb_stall, 2'b01);
      if (k == 6) begin
        chk("lock_next_addr", m_wb_addr, ADDR0);
        chk("lock_next_stall", s_wb_stall, 2'b10);
      end
      if (k == 7) chk("lock_ack1", s_wb_ack, 2'b10);
      if (k == 8) chk("lock_ack0", s_wb_ack, 2'b01);
      tick();
    end
    m_wb_stall = 1'b0;

    // FIFO full with acks withheld
    for (int k = 0; k <= 11; k++) begin
      s_wb_stb = (k <= 6) ? 2'b01 : 2'b00;
      m_wb_ack = (k == 5) || (k >= 7 && k <= 10);
      #2;
      if (k <= 3) chk("full_issue", m_wb_stb, 1);
      if (k == 4) begin
        chk("full_outstanding", outstanding, 4);
        chk("full_m_stb", m_wb_stb, 0);
        chk("full_stall", s_wb_stall, 2'b11);
      end
      if (k == 5) begin
        chk("full_pop_m_stb", m_wb_stb, 0);
        chk("full_pop_ack", s_wb_ack, 2'b01);
      end
      if (k == 6) begin
        chk("full_after_pop_outstanding", outstanding, 3);
        chk("full_after_pop_m_stb", m_wb_stb, 1);
      end
      if (k == 11) chk("full_drained", outstanding, 0);
      tick();
    end
    m_wb_ack = 1'b0;

    // unexpected ack after reset
    do_reset();
    m_wb_ack = 1'b1;
    #2;
    chk("unexp_no_ack", s_wb_ack, 0);
    chk("unexp_err_before", err_ack, 0);
    tick();
    m_wb_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2 chk("unexp_err_sticky", err_ack, 1);
      tick();
    end

    // asynchronous reset with three requests outstanding
    set_m(0, ADDR0, 16'h3333, 1'b1);
    set_m(1, ADDR1, 16'h4444, 1'b0);
    s_wb_stb = 2'b01;
    repeat (3) tick();
    #1 chk("arst_pre_outstanding", outstanding, 3);
    m_wb_ack = 1'b1;
    sresetn = 1'b0;
    #1;
    chk("arst_m_stb", m_wb_stb, 0);
    chk("arst_stall", s_wb_stall, 2'b11);
    chk("arst_ack", s_wb_ack, 0);
    chk("arst_outstanding", outstanding, 0);
    chk("arst_err_ack", err_ack, 0);
    @(posedge clk);
    #1 sresetn = 1'b1;
    m_wb_ack = 1'b0;
    s_wb_stb = 2'b11;
    #2;
    chk("arst_first_gnt", m_wb_addr, ADDR0);
    chk("arst_first_stall", s_wb_stall, 2'b10);
    tick();
    s_wb_stb = '0;
    m_wb_ack = 1'b1;
    tick();
    m_wb_ack = 1'b0;

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      for (int i = 0; i < N; i++) begin
        s_wb_stb[i] = (($urandom % 100) < 60);
        set_m(i, A'($urandom), DW'($urandom), 1'($urandom));
      end
      m_wb_stall   = (($urandom % 100) < 30);
      m_wb_ack     = (mq.size() > 0) ? (($urandom % 100) < 50) : (($urandom % 100) < 3);
      m_wb_dat_s2m = DW'($urandom);
      tick();
    end
    s_wb_stb = '0;
    m_wb_ack = 1'b0;
    m_wb_stall = 1'b0;
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
